// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and token type for the divider issue controller
package div_pkg;

    localparam int DIV_WIDTH   = 16;
    localparam int DIV_LATENCY = 7;
    localparam int DIV_TAG_W   = 4;

    localparam logic [DIV_WIDTH-1:0] DZ_QUOT = '1;

    typedef struct packed {
        logic                 valid;
        logic [DIV_TAG_W-1:0] tag;
        logic                 dz;
    } div_token_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset so it can map onto plain register arrays or RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - credit-gated operand issue and in-order result capture around a free-running divider
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH     = DIV_WIDTH,
    parameter int LATENCY   = DIV_LATENCY,
    parameter int TAG_W     = DIV_TAG_W,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [WIDTH-1:0] pipe_a,
    output logic [WIDTH-1:0] pipe_b,
    input  logic [WIDTH-1:0] pipe_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_dz,
    output logic             busy
);

    localparam int IN_W   = 2*WIDTH + TAG_W;
    localparam int OUT_W  = WIDTH + TAG_W + 1;
    localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
    localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;
    localparam int FL_W   = $clog2(LATENCY + 1);
    localparam int OCC_W  = $clog2(OUT_DEPTH + LATENCY + 1);

    // Same layout as div_token_t, widened to this instance's tag width.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             dz;
    } token_t;

    logic              ready_q;
    logic              in_push;
    logic              in_full;
    logic              in_empty;
    logic [IN_CW-1:0]  in_count;
    logic [IN_W-1:0]   in_head;
    logic [WIDTH-1:0]  head_a;
    logic [WIDTH-1:0]  head_b;
    logic [TAG_W-1:0]  head_tag;

    logic              issue;
    token_t            sr [LATENCY];
    token_t            stage0;
    token_t            tail;
    logic [FL_W-1:0]   inflight;
    logic [OCC_W-1:0]  occupancy;

    logic              out_push;
    logic              out_pop;
    logic              out_full;
    logic              out_empty;
    logic [OUT_CW-1:0] out_count;
    logic [WIDTH-1:0]  cap_q;
    logic [OUT_W-1:0]  out_data;
    logic [OUT_W-1:0]  out_head;

    // Holds in_ready low through the reset edge even though the FIFO reads empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign in_ready = ready_q && !in_full;
    assign in_push  = in_valid && in_ready;

    sync_fifo #(
        .WIDTH (IN_W),
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk       (clk),
        .resetn    (rst),
        .push      (in_push),
        .push_data ({in_a, in_b, in_tag}),
        .pop       (issue),
        .head      (in_head),
        .full      (in_full),
        .empty     (in_empty),
        .count     (in_count)
    );

    assign {head_a, head_b, head_tag} = in_head;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + FL_W'(sr[i].valid);
        end
    end

    // Every in-flight op plus every buffered result must fit in the output FIFO.
    assign occupancy = OCC_W'(inflight) + OCC_W'(out_count);
    assign issue     = !in_empty && (occupancy < OCC_W'(OUT_DEPTH));

    always_comb begin
        stage0 = '0;
        pipe_a = '0;
        pipe_b = '0;
        if (issue) begin
            pipe_a       = head_a;
            pipe_b       = head_b;
            stage0.valid = 1'b1;
            stage0.tag   = head_tag;
            stage0.dz    = (head_b == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= stage0;
            for (int i = 1; i < LATENCY; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign tail     = sr[LATENCY-1];
    assign cap_q    = tail.dz ? WIDTH'(DZ_QUOT) : pipe_res;
    assign out_push = tail.valid && !out_full;
    assign out_data = {cap_q, tail.tag, tail.dz};
    assign out_pop  = out_ready && !out_empty;

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .resetn    (rst),
        .push      (out_push),
        .push_data (out_data),
        .pop       (out_pop),
        .head      (out_head),
        .full      (out_full),
        .empty     (out_empty),
        .count     (out_count)
    );

    assign out_valid                 = !out_empty;
    assign {out_q, out_tag, out_dz}  = out_empty ? '0 : out_head;
    assign busy = (in_count != '0) || (out_count != '0) || (inflight != '0);

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - directed self-checking bench for div_issue_ctrl
module tb_div_issue_ctrl;

    localparam int WIDTH     = 16;
    localparam int LATENCY   = 7;
    localparam int TAG_W     = 4;
    localparam int IN_DEPTH  = 4;
    localparam int OUT_DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic [WIDTH-1:0] pipe_a;
    logic [WIDTH-1:0] pipe_b;
    logic [WIDTH-1:0] pipe_res;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_q;
    logic [TAG_W-1:0] out_tag;
    logic             out_dz;
    logic             busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    div_issue_ctrl #(
        .WIDTH     (WIDTH),
        .LATENCY   (LATENCY),
        .TAG_W     (TAG_W),
        .IN_DEPTH  (IN_DEPTH),
        .OUT_DEPTH (OUT_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .pipe_a    (pipe_a),
        .pipe_b    (pipe_b),
        .pipe_res  (pipe_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_tag   (out_tag),
        .out_dz    (out_dz),
        .busy      (busy)
    );

    // Free-running 7-stage divider; zero divisor yields a junk value the DUT must ignore.
    logic [WIDTH-1:0] dq [LATENCY];
    always @(posedge clk) begin
        dq[0] <= (pipe_b == '0) ? 16'h1234 : pipe_a / pipe_b;
        for (int i = 1; i < LATENCY; i++) dq[i] <= dq[i-1];
    end
    assign pipe_res = dq[LATENCY-1];

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_out(input int limit, output int waited);
        waited = 0;
        while (!out_valid && waited < limit) begin
            tick();
            waited++;
        end
    endtask

    task automatic push_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t, output bit ok);
        int cnt;
        in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            tick();
            cnt++;
        end
        ok = in_ready;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b1; in_a = 16'd77; in_b = 16'd3; in_tag = 4'd1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({in_ready, out_valid, out_q, out_tag, out_dz, pipe_a, pipe_b, busy} !== '0) begin
                fails++;
                $display("FAIL reset_outputs cycle %0d: got rdy=%b ov=%b q=%h tag=%h dz=%b pa=%h pb=%h busy=%b, expected all 0",
                         i, in_ready, out_valid, out_q, out_tag, out_dz, pipe_a, pipe_b, busy);
            end
        end
        rst = 1'b1; in_valid = 1'b0;
        tick();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b, expected 1", in_ready);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_busy: got %b, expected 0", busy);
        end
    endtask

    task automatic test_single;
        int lat;
        out_ready = 1'b0;
        in_a = 16'd100; in_b = 16'd7; in_tag = 4'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tests++;
        if (pipe_a !== 16'd100 || pipe_b !== 16'd7) begin
            fails++;
            $display("FAIL single_issue: got a=%0d b=%0d, expected a=100 b=7", pipe_a, pipe_b);
        end
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        tests++;
        if (lat != 8) begin
            fails++;
            $display("FAIL single_latency: got %0d cycles, expected 8", lat);
        end
        tests++;
        if (out_q !== 16'd14 || out_tag !== 4'd3 || out_dz !== 1'b0) begin
            fails++;
            $display("FAIL single_result: got q=%0d tag=%0d dz=%b, expected q=14 tag=3 dz=0", out_q, out_tag, out_dz);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_drained: got ov=%b busy=%b, expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_div_zero;
        bit ok1, ok2;
        int w;
        out_ready = 1'b0;
        push_op(16'd5, 16'd0, 4'd9, ok1);
        push_op(16'd50, 16'd5, 4'd2, ok2);
        wait_out(20, w);
        tests++;
        if (!ok1 || !ok2 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL dz_arrive: got accepted=%b%b ov=%b, expected 11 1", ok1, ok2, out_valid);
        end
        tests++;
        if (out_q !== 16'hFFFF || out_dz !== 1'b1 || out_tag !== 4'd9) begin
            fails++;
            $display("FAIL dz_result: got q=%h dz=%b tag=%0d, expected q=ffff dz=1 tag=9", out_q, out_dz, out_tag);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_out(5, w);
        tests++;
        if (out_valid !== 1'b1 || out_q !== 16'd10 || out_tag !== 4'd2 || out_dz !== 1'b0) begin
            fails++;
            $display("FAIL dz_follow: got ov=%b q=%0d tag=%0d dz=%b, expected ov=1 q=10 tag=2 dz=0",
                     out_valid, out_q, out_tag, out_dz);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [15:0] exp_q [$];
        logic [3:0]  exp_tag [$];
        logic [15:0] a, b;
        int idx, n, extra;
        bit acc;
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 60; c++) begin
            a = 16'(1000 + idx * 37);
            b = 16'(idx % 9 + 1);
            if (idx < 24) begin
                in_valid = 1'b1; in_a = a; in_b = b; in_tag = 4'(idx % 16);
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                exp_q.push_back(a / b);
                exp_tag.push_back(4'(idx % 16));
                idx++;
            end
        end
        in_valid = 1'b0;
        tests++;
        if (idx != 20 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_accepted: got %0d accepted rdy=%b, expected 20 accepted rdy=0", idx, in_ready);
        end
        out_ready = 1'b1;
        n = 0; extra = 0;
        for (int c = 0; c < 60; c++) begin
            if (out_valid) begin
                if (n < exp_q.size()) begin
                    tests++;
                    if (out_q !== exp_q[n] || out_tag !== exp_tag[n] || out_dz !== 1'b0) begin
                        fails++;
                        $display("FAIL bp_result[%0d]: got q=%0d tag=%0d dz=%b, expected q=%0d tag=%0d dz=0",
                                 n, out_q, out_tag, out_dz, exp_q[n], exp_tag[n]);
                    end
                end else begin
                    extra++;
                end
                n++;
            end
            tick();
        end
        tests++;
        if (n != 20 || extra != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_drain: got %0d results (%0d extra) busy=%b, expected 20 results busy=0", n, extra, busy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_throughput;
        int i, n, first, last, drops;
        bit acc;
        logic [15:0] ea, eb;
        out_ready = 1'b1;
        i = 0; n = 0; first = -1; last = -1; drops = 0;
        for (int c = 0; c < 80; c++) begin
            if (i < 32) begin
                in_valid = 1'b1;
                in_a = 16'(500 + i * 13); in_b = 16'(i % 7 + 1); in_tag = 4'(i % 16);
                if (!in_ready) drops++;
            end else begin
                in_valid = 1'b0;
            end
            if (n == 32 && c == last + 1) begin
                tests++;
                if (busy !== 1'b0 || out_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL tp_busy_fall: got busy=%b ov=%b, expected 0 0", busy, out_valid);
                end
            end
            if (out_valid && n < 32) begin
                ea = 16'(500 + n * 13);
                eb = 16'(n % 7 + 1);
                tests++;
                if (out_q !== ea / eb || out_tag !== 4'(n % 16) || out_dz !== 1'b0) begin
                    fails++;
                    $display("FAIL tp_result[%0d]: got q=%0d tag=%0d, expected q=%0d tag=%0d",
                             n, out_q, out_tag, ea / eb, n % 16);
                end
                if (first < 0) first = c;
                last = c;
                n++;
                if (n == 32) begin
                    tests++;
                    if (busy !== 1'b1) begin
                        fails++;
                        $display("FAIL tp_busy_last: got %b, expected 1", busy);
                    end
                end
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) i++;
        end
        in_valid = 1'b0;
        tests++;
        if (drops != 0 || first != 9 || last - first != 31 || n != 32) begin
            fails++;
            $display("FAIL tp_rate: got drops=%0d first=%0d span=%0d results=%0d, expected drops=0 first=9 span=31 results=32",
                     drops, first, last - first, n);
        end
    endtask

    task automatic test_reset_midflight;
        int seen, w;
        bit ok;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_a = 16'(200 + k); in_b = 16'd3; in_tag = 4'(k + 12);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tests++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_state: got busy=%b rdy=%b, expected 0 0", busy, in_ready);
        end
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) seen++;
            tick();
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL mid_discard: got %0d stale results, expected 0", seen);
        end
        push_op(16'd81, 16'd9, 4'd5, ok);
        wait_out(20, w);
        tests++;
        if (!ok || out_valid !== 1'b1 || out_q !== 16'd9 || out_tag !== 4'd5 || out_dz !== 1'b0) begin
            fails++;
            $display("FAIL mid_after: got ok=%b ov=%b q=%0d tag=%0d dz=%b, expected ok=1 ov=1 q=9 tag=5 dz=0",
                     ok, out_valid, out_q, out_tag, out_dz);
        end
        tick();
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_div_zero();
        test_backpressure();
        test_throughput();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Operand-issue and result-collection controller that sits directly upstream and downstream of the 7-stage free-running divider chain. Accepts operand pairs over a valid/ready handshake and buffers them in an input FIFO. Issues them into the non-stallable divider pipeline only when result space is guaranteed, then tracks each operation with a valid/tag shift register aligned to the pipeline latency. Captures emerging quotients into an output FIFO, presenting them in order with a tag and a divide-by-zero flag.

## Interface
- WIDTH, 16: operand/quotient width.
- LATENCY, 7: divider chain depth; the result appears on pipe_res LATENCY cycles after issue.
- TAG_W, 4: width of the user tag.
- IN_DEPTH, 4: input FIFO entries; power of 2.
- OUT_DEPTH, 16: output FIFO entries; power of 2, must be ≥ LATENCY+2 for one-op-per-cycle throughput.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low (0 = reset).
- in_valid  in  1  operand pair offered.
- in_ready  out  1  input FIFO not full.
- in_a  in  WIDTH  dividend.
- in_b  in  WIDTH  divisor.
- in_tag  in  TAG_W  user tag, returned with the result.
- pipe_a  out  WIDTH  dividend to divider stage 1; 0 when not issuing.
- pipe_b  out  WIDTH  divisor to divider stage 1; 0 when not issuing.
- pipe_res  in  WIDTH  quotient from the last divider stage.
- out_valid  out  1  output FIFO not empty.
- out_ready  in  1  consumer accepts the head entry.
- out_q  out  WIDTH  quotient at the head; 0 when empty.
- out_tag  out  TAG_W  tag at the head; 0 when empty.
- out_dz  out  1  head entry had divisor 0; 0 when empty.
- busy  out  1  any FIFO non-empty or any operation in flight.

## Operation
- Accept: an entry is pushed at an edge where in_valid && in_ready. in_ready = !in_full; there is no pass-through when full, even if a pop occurs in the same cycle.
- Issue condition: input FIFO non-empty && (inflight + out_count) < OUT_DEPTH.
  - inflight = popcount of the shift-register valid bits.
  - The check uses registered counts only, so it is conservative; the output FIFO can never overflow.
- Issue action: drive pipe_a/pipe_b from the FIFO head for that cycle, pop the head, and load stage 0 of the shift register with {valid=1, tag, dz=(b==0)}.
- Non-issue cycle: pipe_a/pipe_b are 0 and stage 0 is loaded with valid=0.
- Shift register: LATENCY entries, advances every cycle unconditionally, matching the free-running divider.
- Capture: when the tail entry is valid, push {q, tag, dz} into the output FIFO.
  - q = all-ones (DZ_QUOT) if dz is set, otherwise pipe_res.
  - Divider output for a zero divisor is ignored.
- Divide-by-zero operations still occupy a pipeline slot, which preserves ordering.
- Output: a pop occurs at an edge where out_valid && out_ready. Results leave in acceptance order.
- Simultaneous capture and pop on the output FIFO is allowed; the count is unchanged.

## Timing
- Reset (rst=0 at an edge), values after that edge:
  - in_ready=0, pipe_a=pipe_b=0, out_valid=0, out_q=0, out_tag=0, out_dz=0, busy=0.
  - Both FIFOs empty, all shift-register valid bits cleared.
- in_ready goes to 1 at the first edge with rst=1.
- Reset mid-operation: all queued and in-flight operations are discarded. Quotients still emerging from the divider after reset are never captured.
- Latency: for an operation accepted at edge E into an empty system with credit available:
  - issue occurs in the cycle after E;
  - capture occurs at edge E+LATENCY+1;
  - out_valid is high after that edge, i.e. LATENCY+1 = 8 cycles by default.
- Throughput: one operation per cycle sustained when out_ready=1 and OUT_DEPTH ≥ LATENCY+2.
- Backpressure: with out_ready held 0, at most OUT_DEPTH + IN_DEPTH operations are accepted.

## Structure
- Shared package div_pkg holds:
  - constants DIV_WIDTH=16, DIV_LATENCY=7, DIV_TAG_W=4;
  - DZ_QUOT = all-ones;
  - typedef of the in-flight token {valid, tag, dz}.
- Sub-module sync_fifo (parameterised width/depth, registered count, full/empty), instantiated twice:
  - input FIFO: 2·WIDTH+TAG_W bits;
  - output FIFO: WIDTH+TAG_W+1 bits.
- The shift register and credit logic live in div_issue_ctrl.

## Test plan
- Reset: hold rst=0 for 3 cycles with in_valid=1 -> every output stays 0 and in_ready=0; in_ready=1 after the first edge with rst=1.
- Single op: a=100, b=7, tag=3 through the real 7-stage chain -> out_q=14, out_tag=3, out_dz=0, with out_valid rising exactly 8 cycles after the accepting edge.
- Divide-by-zero: a=5, b=0, tag=9 -> out_q=0xFFFF, out_dz=1, out_tag=9 regardless of pipe_res. A following op 50/5 returns 10 in order.
- Backpressure: out_ready=0, offer 24 ops with tags 0..15 repeating -> exactly 20 accepted before in_ready stays 0. Release out_ready -> all 20 emerge in order with correct quotients, none lost or duplicated.
- Throughput: out_ready=1, 32 back-to-back ops -> in_ready never drops, one result per cycle after the first 8-cycle latency, busy falls 1 cycle after the last pop.
- Reset mid-flight: 3 ops issued, rst=0 for 1 cycle 2 cycles later -> none of the 3 ever appears on out_valid. A new op 81/9 issued after reset returns 9.
